mem_cycle_seq: RTL and testbench
================================

// Module: mem_cycle_seq
// PURPOSE
//  Bus-cycle sequencer directly downstream of the MMU. Takes the CPU read/write request plus the
//  MMU's translated 22-bit physical address and page-writable flag, runs a timed cycle on the
//  16-bit external SRAM, and returns data and an interlocked reply to the CPU. Writes to
//  read-only pages are aborted with no SRAM strobe; addresses beyond installed memory time out.
// PARAMETERS
//  WAIT_RD   2      SRAM read strobe length, ce-cycles (1..15)
//  WAIT_WR   2      SRAM write strobe length, ce-cycles (1..15)
//  MEM_TOP   22'h100000  first non-existent physical byte address
//  TMO       31     ce-cycles before a non-existent-memory cycle raises timeout (1..255)
// PORTS
//  clk          in   1   system clock
//  reset_n      in   1   async active-low reset
//  ce           in   1   clock enable; state, counters and outputs advance only when ce=1
//  req_rd       in   1   CPU read request (level, held until reply/abort/timeout)
//  req_wr       in   1   CPU write request (level)
//  req_byte     in   1   byte access; lane selected by phaddr[0]
//  mmu_valid    in   1   MMU translation valid; requests ignored while 0
//  phaddr       in   22  physical byte address from MMU
//  writable     in   1   page write-enable from MMU
//  cpu_dout     in   16  write data from CPU
//  cpu_din      out  16  read data to CPU
//  rply         out  1   cycle done (held until request drops)
//  abort        out  1   write-protect violation, one ce-cycle pulse
//  timeout      out  1   non-existent memory, one ce-cycle pulse
//  busy         out  1   1 in any state except IDLE
//  sram_addr    out  21  SRAM word address (phaddr[21:1])
//  sram_dq_o    out  16  SRAM write data
//  sram_dq_i    in   16  SRAM read data
//  sram_oe_n    out  1   SRAM output enable, active low
//  sram_we_n    out  1   SRAM write enable, active low
//  sram_be_n    out  2   byte enables, [0]=low byte, active low
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; oe_n=we_n=1, be_n=2'b11, sram_addr=0, dq_o=0,
//   cpu_din=0, rply=abort=timeout=busy=0, wait counter=0.
//  FSM states: IDLE, READ, WRITE, NXM, REPLY, ERR. All outputs registered.
//  IDLE: on ce & mmu_valid & (req_rd|req_wr): latch phaddr, byte, cpu_dout, writable. Priority:
//   req_rd&req_wr -> read only. phaddr>=MEM_TOP -> NXM. write & !writable -> ERR with abort=1.
//   else read -> READ, write -> WRITE. Counter loaded with WAIT_RD/WAIT_WR.
//  READ: oe_n=0, be_n=2'b00 for WAIT_RD ce-cycles; on last cycle cpu_din<=sram_dq_i (full word;
//   CPU selects lane), oe_n->1, go REPLY.
//  WRITE: we_n=0 for WAIT_WR ce-cycles. Word: be_n=00, dq_o=cpu_dout, phaddr[0] ignored.
//   Byte: dq_o={cpu_dout[7:0],cpu_dout[7:0]}, be_n=phaddr[0]?2'b01:2'b10. Then we_n->1, REPLY.
//   sram_addr/dq_o/be_n stable one ce-cycle before and the whole strobe.
//  Latency (ce=1 every clk): read rply = WAIT_RD+2 clks after request seen; write = WAIT_WR+2.
//  REPLY: rply=1 while req_rd|req_wr; when both 0 -> rply=0, IDLE. If request already dropped
//   on entry, rply pulses one ce-cycle. SRAM cycle never truncated by request drop.
//  NXM: count TMO ce-cycles, no SRAM strobe; then timeout=1 one cycle -> ERR.
//  ERR: abort/timeout cleared after one cycle; stay until req_rd|req_wr both 0, then IDLE.
//  New request never accepted in the same cycle REPLY/ERR exits (one IDLE cycle minimum).
//  ce=0: everything frozen including strobes and counters.
//  Reset mid-cycle: strobes released asynchronously; no reply/abort generated.
// TESTING
//  WAIT_RD=2, word read phaddr=22'h000100, SRAM word 16'h1234 -> oe_n low 2 cycles, cpu_din=1234, rply.
//  Byte write phaddr=22'h000201, cpu_dout=16'h00AB -> sram_addr=21'h100, dq_o=ABAB, be_n=01, we_n low 2 cycles.
//  Write with writable=0 -> no we_n pulse, abort 1 cycle, no rply; idle after req drop.
//  Read phaddr=MEM_TOP, TMO=31 -> no strobe, timeout exactly 32 ce-cycles after request, no rply.
//  ce toggled 1/0 during READ -> strobe length counts only ce-cycles; data and timing correct.
//  reset_n asserted mid-WRITE -> we_n=1, be_n=11 immediately; next request runs normally.

Source files
------------

// File: rtl/mem_cycle_seq_if.sv
// mem_cycle_seq_if: CPU/MMU request, CPU reply and SRAM bus signals of the cycle sequencer
interface mem_cycle_seq_if;
  logic        req_rd;
  logic        req_wr;
  logic        req_byte;
  logic        mmu_valid;
  logic [21:0] phaddr;
  logic        writable;
  logic [15:0] cpu_dout;
  logic [15:0] cpu_din;
  logic        rply;
  logic        abort;
  logic        timeout;
  logic        busy;
  logic [20:0] sram_addr;
  logic [15:0] sram_dq_o;
  logic [15:0] sram_dq_i;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [1:0]  sram_be_n;
  modport slave (
    input  req_rd, req_wr, req_byte, mmu_valid, phaddr, writable, cpu_dout, sram_dq_i,
    output cpu_din, rply, abort, timeout, busy, sram_addr, sram_dq_o, sram_oe_n, sram_we_n, sram_be_n
  );
  modport master (
    output req_rd, req_wr, req_byte, mmu_valid, phaddr, writable, cpu_dout, sram_dq_i,
    input  cpu_din, rply, abort, timeout, busy, sram_addr, sram_dq_o, sram_oe_n, sram_we_n, sram_be_n
  );
endinterface

// File: rtl/mem_cycle_seq.sv
// mem_cycle_seq: runs timed SRAM read/write cycles for MMU-translated CPU requests
module mem_cycle_seq #(
  parameter int          WAIT_RD = 2,
  parameter int          WAIT_WR = 2,
  parameter logic [21:0] MEM_TOP = 22'h100000,
  parameter int          TMO     = 31
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ce,
  mem_cycle_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, READ, WRITE, NXM, REPLY, ERR} state_t;
  state_t     state;
  logic [7:0] cnt;
  logic       req;
  assign req = bus.req_rd | bus.req_wr;
  // Sequencer: the cycle after acceptance is address/data setup, then the strobe runs
  // for cnt ce-cycles; a high strobe inside READ/WRITE marks the setup cycle.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= 8'd0;
      bus.sram_oe_n <= 1'b1;
      bus.sram_we_n <= 1'b1;
      bus.sram_be_n <= 2'b11;
      bus.sram_addr <= 21'd0;
      bus.sram_dq_o <= 16'd0;
      bus.cpu_din   <= 16'd0;
      bus.rply      <= 1'b0;
      bus.abort     <= 1'b0;
      bus.timeout   <= 1'b0;
      bus.busy      <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE:
          if (bus.mmu_valid && req) begin
            bus.busy <= 1'b1;
            if (bus.phaddr >= MEM_TOP) begin
              state <= NXM;
              cnt   <= 8'(TMO);
            end else if (!bus.req_rd && !bus.writable) begin
              state     <= ERR;
              bus.abort <= 1'b1;
            end else if (bus.req_rd) begin
              state         <= READ;
              cnt           <= 8'(WAIT_RD);
              bus.sram_addr <= bus.phaddr[21:1];
              bus.sram_be_n <= 2'b00;
            end else begin
              state         <= WRITE;
              cnt           <= 8'(WAIT_WR);
              bus.sram_addr <= bus.phaddr[21:1];
              bus.sram_be_n <= !bus.req_byte ? 2'b00 : bus.phaddr[0] ? 2'b01 : 2'b10;
              bus.sram_dq_o <= bus.req_byte ? {2{bus.cpu_dout[7:0]}} : bus.cpu_dout;
            end
          end
        READ:
          if (bus.sram_oe_n) bus.sram_oe_n <= 1'b0;
          else if (cnt == 8'd1) begin
            bus.cpu_din   <= bus.sram_dq_i;
            bus.sram_oe_n <= 1'b1;
            bus.sram_be_n <= 2'b11;
            bus.rply      <= 1'b1;
            cnt           <= 8'd0;
            state         <= REPLY;
          end else cnt <= cnt - 8'd1;
        WRITE:
          if (bus.sram_we_n) bus.sram_we_n <= 1'b0;
          else if (cnt == 8'd1) begin
            bus.sram_we_n <= 1'b1;
            bus.sram_be_n <= 2'b11;
            bus.rply      <= 1'b1;
            cnt           <= 8'd0;
            state         <= REPLY;
          end else cnt <= cnt - 8'd1;
        NXM:
          if (cnt == 8'd1) begin
            bus.timeout <= 1'b1;
            cnt         <= 8'd0;
            state       <= ERR;
          end else cnt <= cnt - 8'd1;
        REPLY:
          if (!req) begin
            bus.rply <= 1'b0;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        ERR: begin
          bus.abort   <= 1'b0;
          bus.timeout <= 1'b0;
          if (!req) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_cycle_seq.sv
// tb_mem_cycle_seq: vector table plus scoreboard check of the SRAM cycle sequencer
module tb_mem_cycle_seq;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ce = 1'b1;
  logic [15:0] mem [0:511];
  int compared = 0;
  int mism = 0;
  mem_cycle_seq_if bus();
  mem_cycle_seq dut (.clk(clk), .reset_n(reset_n), .ce(ce), .bus(bus.slave));
  always #5 clk = ~clk;
  assign bus.sram_dq_i = mem[bus.sram_addr[8:0]];
  always @(posedge clk)
    if (!bus.sram_we_n) begin
      if (!bus.sram_be_n[0]) mem[bus.sram_addr[8:0]][7:0] = bus.sram_dq_o[7:0];
      if (!bus.sram_be_n[1]) mem[bus.sram_addr[8:0]][15:8] = bus.sram_dq_o[15:8];
    end
  typedef struct {
    logic rd; logic wr; logic byt; logic [21:0] addr; logic wrt; logic [15:0] dout;
    int kind; logic [15:0] din; int lat; int n_oe; int n_we; logic [1:0] be; logic [15:0] dq; bit tog;
  } vec_t;
  typedef struct { int kind; logic [15:0] din; int lat; } exp_t;
  exp_t sb[$];
  vec_t vecs [0:14];
  task automatic chk(input string name, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mism++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic step(input bit tog, output bit had_ce);
    ce = tog ? ~ce : 1'b1;
    had_ce = ce;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic ce_step(input bit tog);
    bit hc;
    hc = 1'b0;
    for (int i = 0; i < 8 && !hc; i++) step(tog, hc);
  endtask
  task automatic run(input vec_t v);
    int n, oe, we, bad, got;
    bit hc, done;
    exp_t e;
    e.kind = v.kind; e.din = v.din; e.lat = v.lat;
    sb.push_back(e);
    bus.req_rd = v.rd; bus.req_wr = v.wr; bus.req_byte = v.byt; bus.phaddr = v.addr;
    bus.writable = v.wrt; bus.cpu_dout = v.dout; bus.mmu_valid = 1'b1;
    n = 0; oe = 0; we = 0; bad = 0; done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      step(v.tog, hc);
      if (hc) begin
        n++;
        if (!bus.sram_oe_n) oe++;
        if (!bus.sram_we_n) begin
          we++;
          if (bus.sram_addr != v.addr[21:1] || bus.sram_dq_o != v.dq || bus.sram_be_n != v.be) bad++;
        end
        if (bus.rply || bus.abort || bus.timeout) done = 1'b1;
      end
    end
    e = sb.pop_front();
    if (!done) chk("no_response", 0, 1);
    else begin
      got = bus.rply ? 0 : bus.abort ? 1 : 2;
      chk("kind", got, e.kind);
      chk("latency", n, e.lat);
      if (e.kind == 0 && v.rd) chk("cpu_din", int'(bus.cpu_din), int'(e.din));
    end
    chk("oe_len", oe, v.n_oe);
    chk("we_len", we, v.n_we);
    chk("wr_bus", bad, 0);
    ce_step(v.tog);
    if (v.kind == 0) chk("rply_held", int'(bus.rply), 1);
    else chk("pulse_clr", int'({bus.rply, bus.abort, bus.timeout}), 0);
    bus.req_rd = 1'b0; bus.req_wr = 1'b0; bus.mmu_valid = 1'b0;
    ce_step(v.tog);
    chk("idle", int'({bus.rply, bus.busy}), 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    mem[9'h080] = 16'h1234;
    mem[9'h100] = 16'h5566;
    bus.req_rd = 1'b0; bus.req_wr = 1'b0; bus.req_byte = 1'b0; bus.mmu_valid = 1'b0;
    bus.phaddr = 22'd0; bus.writable = 1'b0; bus.cpu_dout = 16'd0;
    //          rd    wr    byte  addr         wrt   dout      kind din    lat n_oe n_we be     dq        tog
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 22'h000100, 1'b1, 16'h0000, 0, 16'h1234, 4, 2, 0, 2'b00, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 22'h000201, 1'b1, 16'h00AB, 0, 16'h0000, 4, 0, 2, 2'b01, 16'hABAB, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 22'h000200, 1'b1, 16'h0000, 0, 16'hAB66, 4, 2, 0, 2'b00, 16'h0000, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 22'h000202, 1'b1, 16'hBEEF, 0, 16'h0000, 4, 0, 2, 2'b00, 16'hBEEF, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 22'h000202, 1'b1, 16'h1177, 0, 16'h0000, 4, 0, 2, 2'b10, 16'h7777, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 22'h000203, 1'b1, 16'h0000, 0, 16'hBE77, 4, 2, 0, 2'b00, 16'h0000, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 22'h000100, 1'b0, 16'hFFFF, 1, 16'h0000, 1, 0, 0, 2'b00, 16'h0000, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 22'h000100, 1'b0, 16'h0000, 0, 16'h1234, 4, 2, 0, 2'b00, 16'h0000, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 22'h100000, 1'b1, 16'h0000, 2, 16'h0000, 32, 0, 0, 2'b00, 16'h0000, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 22'h000100, 1'b1, 16'h0000, 0, 16'h1234, 4, 2, 0, 2'b00, 16'h0000, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 22'h100000, 1'b0, 16'h0000, 2, 16'h0000, 32, 0, 0, 2'b00, 16'h0000, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 22'h000200, 1'b1, 16'h0000, 0, 16'hAB66, 4, 2, 0, 2'b00, 16'h0000, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 22'h000203, 1'b1, 16'h00CD, 0, 16'h0000, 4, 0, 2, 2'b01, 16'hCDCD, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 22'h000202, 1'b1, 16'h0000, 0, 16'hCD77, 4, 2, 0, 2'b00, 16'h0000, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 22'h0FFFFE, 1'b1, 16'h0000, 0, 16'h0000, 4, 2, 0, 2'b00, 16'h0000, 1'b0};
    @(negedge clk);
    @(negedge clk);
    chk("reset_strobes", int'({bus.sram_oe_n, bus.sram_we_n, bus.sram_be_n}), 'hF);
    chk("reset_bus", int'({bus.sram_addr, bus.sram_dq_o}), 0);
    chk("reset_cpu", int'({bus.cpu_din, bus.rply, bus.abort, bus.timeout, bus.busy}), 0);
    reset_n = 1'b1;
    @(negedge clk);
    bus.req_rd = 1'b1; bus.phaddr = 22'h000100; bus.mmu_valid = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("no_mmu_valid", int'({bus.busy, bus.sram_oe_n}), 1);
    bus.req_rd = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 15; i++) run(vecs[i]);
    bus.req_wr = 1'b1; bus.req_byte = 1'b0; bus.phaddr = 22'h000300;
    bus.writable = 1'b1; bus.cpu_dout = 16'h5A5A; bus.mmu_valid = 1'b1;
    ce = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("mid_write_we", int'(bus.sram_we_n), 0);
    reset_n = 1'b0;
    #1;
    chk("rst_we_be", int'({bus.sram_we_n, bus.sram_be_n}), 7);
    chk("rst_no_reply", int'({bus.rply, bus.abort, bus.busy}), 0);
    bus.req_wr = 1'b0; bus.mmu_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run(vecs[0]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
